// File: rtl/gpr_writeback_arbiter.sv
// Write-side controller for the GPR file: arbitrates ALU and buffered load results onto the
// single write port, tracks pending destinations and reports hazards/forwarding for two read selects.
module gpr_writeback_arbiter #(
    parameter int num_regs       = 32,
    parameter int l2_num_regs    = 5,
    parameter int lsu_fifo_depth = 2,
    parameter int word_size      = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_issue_valid,
    input  logic [l2_num_regs-1:0] i_issue_rd,
    output logic                   o_issue_ready,
    input  logic                   i_alu_valid,
    input  logic [l2_num_regs-1:0] i_alu_rd,
    input  logic [word_size-1:0]   i_alu_data,
    output logic                   o_alu_ready,
    input  logic                   i_lsu_valid,
    input  logic [l2_num_regs-1:0] i_lsu_rd,
    input  logic [word_size-1:0]   i_lsu_data,
    output logic                   o_lsu_ready,
    output logic                   o_load_gpr,
    output logic [l2_num_regs-1:0] o_load_gpr_sel,
    output logic [word_size-1:0]   o_load_gpr_data,
    input  logic [l2_num_regs-1:0] i_read_gpr_A_sel,
    input  logic [l2_num_regs-1:0] i_read_gpr_B_sel,
    output logic                   o_hazard_A,
    output logic                   o_hazard_B,
    output logic                   o_fwd_A_valid,
    output logic                   o_fwd_B_valid,
    output logic [word_size-1:0]   o_fwd_A_data,
    output logic [word_size-1:0]   o_fwd_B_data,
    output logic [num_regs-1:0]    o_pending,
    output logic                   o_busy
);
    localparam int ptr_w = (lsu_fifo_depth > 1) ? $clog2(lsu_fifo_depth) : 1;
    localparam int cnt_w = $clog2(lsu_fifo_depth + 1);

    logic [l2_num_regs-1:0] r_fifo_rd   [lsu_fifo_depth];
    logic [word_size-1:0]   r_fifo_data [lsu_fifo_depth];
    logic [ptr_w-1:0]       r_wr_ptr;
    logic [ptr_w-1:0]       r_rd_ptr;
    logic [cnt_w-1:0]       r_count;

    logic                   r_load_gpr;
    logic [l2_num_regs-1:0] r_load_gpr_sel;
    logic [word_size-1:0]   r_load_gpr_data;
    logic [num_regs-1:0]    r_pending;
    logic [num_regs-1:0]    w_pending_next;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_alu_win;
    logic                   w_win_valid;
    logic [l2_num_regs-1:0] w_win_rd;
    logic [word_size-1:0]   w_win_data;
    logic                   w_issue_fire;

    assign w_fifo_full  = (r_count == cnt_w'(lsu_fifo_depth));
    assign w_fifo_empty = (r_count == '0);

    // A full buffer takes priority so loads can never be starved by a continuous ALU stream.
    assign o_alu_ready  = !w_fifo_full;
    assign o_lsu_ready  = !w_fifo_full;
    assign w_alu_win    = i_alu_valid && !w_fifo_full;
    assign w_pop        = !w_fifo_empty && !w_alu_win;
    assign w_push       = i_lsu_valid && !w_fifo_full;
    assign w_win_valid  = w_alu_win || w_pop;
    assign w_win_rd     = w_alu_win ? i_alu_rd : r_fifo_rd[r_rd_ptr];
    assign w_win_data   = w_alu_win ? i_alu_data : r_fifo_data[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= i_lsu_rd;
            r_fifo_data[r_wr_ptr] <= i_lsu_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_w'(1);
            if (w_push && !w_pop)      r_count <= r_count + cnt_w'(1);
            else if (!w_push && w_pop) r_count <= r_count - cnt_w'(1);
        end
    end

    // A winner targeting r0 still consumes its slot but never raises the write enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load_gpr      <= 1'b0;
            r_load_gpr_sel  <= '0;
            r_load_gpr_data <= '0;
        end else begin
            r_load_gpr <= w_win_valid && (w_win_rd != '0);
            if (w_win_valid) begin
                r_load_gpr_sel  <= w_win_rd;
                r_load_gpr_data <= w_win_data;
            end
        end
    end

    assign o_issue_ready = (i_issue_rd == '0) || !r_pending[i_issue_rd];
    assign w_issue_fire  = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

    assign w_pending_next[0] = 1'b0;
    for (genvar gi = 1; gi < num_regs; gi++) begin : g_pend
        // Set beats clear when an issue lands on the register being written back.
        assign w_pending_next[gi] =
            (w_issue_fire && (i_issue_rd == l2_num_regs'(gi))) ||
            (r_pending[gi] && !(r_load_gpr && (r_load_gpr_sel == l2_num_regs'(gi))));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pending <= '0;
        else          r_pending <= w_pending_next;
    end

    assign o_fwd_A_valid = (i_read_gpr_A_sel != '0) && r_load_gpr && (r_load_gpr_sel == i_read_gpr_A_sel);
    assign o_fwd_B_valid = (i_read_gpr_B_sel != '0) && r_load_gpr && (r_load_gpr_sel == i_read_gpr_B_sel);
    assign o_hazard_A    = (i_read_gpr_A_sel != '0) && r_pending[i_read_gpr_A_sel] && !o_fwd_A_valid;
    assign o_hazard_B    = (i_read_gpr_B_sel != '0) && r_pending[i_read_gpr_B_sel] && !o_fwd_B_valid;
    assign o_fwd_A_data  = r_load_gpr_data;
    assign o_fwd_B_data  = r_load_gpr_data;

    assign o_load_gpr      = r_load_gpr;
    assign o_load_gpr_sel  = r_load_gpr_sel;
    assign o_load_gpr_data = r_load_gpr_data;
    assign o_pending       = r_pending;
    assign o_busy          = !w_fifo_empty || r_load_gpr || (|r_pending);
endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed vector bench for gpr_writeback_arbiter: table of per-cycle inputs and expected outputs,
// followed by a hand-written asynchronous reset sequence.
module tb_gpr_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        load_gpr;
    logic [4:0]  load_sel;
    logic [31:0] load_data;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic        haz_a;
    logic        haz_b;
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;
    logic [31:0] pending;
    logic        busy;

    always #5 clk = ~clk;

    gpr_writeback_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_issue_valid   (issue_valid),
        .i_issue_rd      (issue_rd),
        .o_issue_ready   (issue_ready),
        .i_alu_valid     (alu_valid),
        .i_alu_rd        (alu_rd),
        .i_alu_data      (alu_data),
        .o_alu_ready     (alu_ready),
        .i_lsu_valid     (lsu_valid),
        .i_lsu_rd        (lsu_rd),
        .i_lsu_data      (lsu_data),
        .o_lsu_ready     (lsu_ready),
        .o_load_gpr      (load_gpr),
        .o_load_gpr_sel  (load_sel),
        .o_load_gpr_data (load_data),
        .i_read_gpr_A_sel(sel_a),
        .i_read_gpr_B_sel(sel_b),
        .o_hazard_A      (haz_a),
        .o_hazard_B      (haz_b),
        .o_fwd_A_valid   (fwd_a),
        .o_fwd_B_valid   (fwd_b),
        .o_fwd_A_data    (fwd_a_data),
        .o_fwd_B_data    (fwd_b_data),
        .o_pending       (pending),
        .o_busy          (busy)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        e_iready;
        logic        e_aready;
        logic        e_lready;
        logic        e_load;
        logic [4:0]  e_sel;
        logic [31:0] e_data;
        logic        e_ha;
        logic        e_hb;
        logic        e_fa;
        logic        e_fb;
        logic [31:0] e_pend;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_miss = 0;

    function automatic void add(input int iv, input int ird, input int av, input int ard, input int adata,
                                input int lv, input int lrd, input int ldata, input int sa, input int sb,
                                input int ir, input int ar, input int lr, input int ld, input int sel,
                                input int data, input int ha, input int hb, input int fa, input int fb,
                                input int pend, input int bz);
        vec_t v;
        v.iv = 1'(iv);   v.ird = 5'(ird);
        v.av = 1'(av);   v.ard = 5'(ard);  v.adata = 32'(adata);
        v.lv = 1'(lv);   v.lrd = 5'(lrd);  v.ldata = 32'(ldata);
        v.sa = 5'(sa);   v.sb = 5'(sb);
        v.e_iready = 1'(ir); v.e_aready = 1'(ar); v.e_lready = 1'(lr);
        v.e_load = 1'(ld);   v.e_sel = 5'(sel);   v.e_data = 32'(data);
        v.e_ha = 1'(ha); v.e_hb = 1'(hb); v.e_fa = 1'(fa); v.e_fb = 1'(fb);
        v.e_pend = 32'(pend); v.e_busy = 1'(bz);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    initial begin
        // iv ird  av ard adata       lv lrd ldata  sa sb  ir ar lr  ld sel data        hA hB fA fB  pend  busy
        add(1,5,  0,0,0,            0,0,0,       5,0,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  1,5,'hDEADBEEF,   0,0,0,       5,0,  1,1,1, 0,0,0,            1,0,0,0, 'h20, 1);
        add(0,0,  0,0,0,            0,0,0,       5,0,  1,1,1, 1,5,'hDEADBEEF,   0,0,1,0, 'h20, 1);
        add(0,0,  0,0,0,            0,0,0,       5,0,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  1,3,'h11,         1,4,'h22,    3,4,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  0,0,0,            0,0,0,       3,4,  1,1,1, 1,3,'h11,         0,0,1,0, 'h0,  1);
        add(0,0,  0,0,0,            0,0,0,       3,4,  1,1,1, 1,4,'h22,         0,0,0,1, 'h0,  1);
        add(0,0,  0,0,0,            0,0,0,       3,4,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  1,1,'hA1,         1,8,'h80,    8,9,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  1,1,'hA2,         1,9,'h90,    8,9,  1,1,1, 1,1,'hA1,         0,0,0,0, 'h0,  1);
        add(0,0,  1,1,'hA3,         1,10,'hA0,   8,9,  1,0,0, 1,1,'hA2,         0,0,0,0, 'h0,  1);
        add(0,0,  1,1,'hA3,         1,10,'hA0,   8,9,  1,1,1, 1,8,'h80,         0,0,1,0, 'h0,  1);
        add(0,0,  1,1,'hA4,         0,0,0,       8,9,  1,0,0, 1,1,'hA3,         0,0,0,0, 'h0,  1);
        add(0,0,  1,1,'hA4,         0,0,0,       8,9,  1,1,1, 1,9,'h90,         0,0,0,1, 'h0,  1);
        add(0,0,  0,0,0,            0,0,0,       8,9,  1,1,1, 1,1,'hA4,         0,0,0,0, 'h0,  1);
        add(0,0,  0,0,0,            0,0,0,       8,9,  1,1,1, 1,10,'hA0,        0,0,0,0, 'h0,  1);
        add(0,0,  0,0,0,            0,0,0,       8,9,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(1,6,  1,0,'hFFFFFFFF,   0,0,0,       6,0,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  0,0,0,            0,0,0,       6,0,  1,1,1, 0,0,0,            1,0,0,0, 'h40, 1);
        add(1,7,  0,0,0,            0,0,0,       6,7,  1,1,1, 0,0,0,            1,0,0,0, 'h40, 1);
        add(1,7,  0,0,0,            0,0,0,       6,7,  0,1,1, 0,0,0,            1,1,0,0, 'hC0, 1);
        add(1,7,  1,7,'h77,         0,0,0,       6,7,  0,1,1, 0,0,0,            1,1,0,0, 'hC0, 1);
        add(1,7,  0,0,0,            0,0,0,       6,7,  0,1,1, 1,7,'h77,         1,0,0,1, 'hC0, 1);
        add(1,7,  0,0,0,            0,0,0,       6,7,  1,1,1, 0,0,0,            1,0,0,0, 'h40, 1);
        add(1,0,  0,0,0,            0,0,0,       6,7,  1,1,1, 0,0,0,            1,1,0,0, 'hC0, 1);
        add(0,0,  1,6,'h66,         0,0,0,       6,7,  1,1,1, 0,0,0,            1,1,0,0, 'hC0, 1);
        add(0,0,  1,7,'h07,         0,0,0,       6,7,  1,1,1, 1,6,'h66,         0,1,1,0, 'hC0, 1);
        add(0,0,  0,0,0,            0,0,0,       6,7,  1,1,1, 1,7,'h07,         0,0,0,1, 'h80, 1);
        add(0,0,  0,0,0,            0,0,0,       6,7,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(0,0,  1,9,'h99,         0,0,0,       9,0,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);
        add(1,9,  0,0,0,            0,0,0,       9,0,  1,1,1, 1,9,'h99,         0,0,1,0, 'h0,  1);
        add(0,0,  0,0,0,            0,0,0,       9,0,  1,1,1, 0,0,0,            1,0,0,0, 'h200,1);
        add(0,0,  1,9,'h9A,         0,0,0,       9,0,  1,1,1, 0,0,0,            1,0,0,0, 'h200,1);
        add(0,0,  0,0,0,            0,0,0,       9,0,  1,1,1, 1,9,'h9A,         0,0,1,0, 'h200,1);
        add(0,0,  0,0,0,            0,0,0,       9,0,  1,1,1, 0,0,0,            0,0,0,0, 'h0,  0);

        idle_inputs();
        sel_a = 5'd5;
        sel_b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        chk("reset load_gpr", 32'(load_gpr), 32'd0);
        chk("reset sel", 32'(load_sel), 32'd0);
        chk("reset data", load_data, 32'd0);
        chk("reset pending", pending, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset lsu_ready", 32'(lsu_ready), 32'd1);
        chk("reset hazard_A", 32'(haz_a), 32'd0);
        $display("vec reset: load=%0b pend=%h busy=%0b", load_gpr, pending, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue_valid = vecs[i].iv;  issue_rd = vecs[i].ird;
            alu_valid = vecs[i].av;    alu_rd = vecs[i].ard;  alu_data = vecs[i].adata;
            lsu_valid = vecs[i].lv;    lsu_rd = vecs[i].lrd;  lsu_data = vecs[i].ldata;
            sel_a = vecs[i].sa;        sel_b = vecs[i].sb;
            #2;
            n_vec++;
            chk($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_iready));
            chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_aready));
            chk($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lready));
            chk($sformatf("v%0d load_gpr", i), 32'(load_gpr), 32'(vecs[i].e_load));
            if (vecs[i].e_load) begin
                chk($sformatf("v%0d load_sel", i), 32'(load_sel), 32'(vecs[i].e_sel));
                chk($sformatf("v%0d load_data", i), load_data, vecs[i].e_data);
            end
            chk($sformatf("v%0d hazard_A", i), 32'(haz_a), 32'(vecs[i].e_ha));
            chk($sformatf("v%0d hazard_B", i), 32'(haz_b), 32'(vecs[i].e_hb));
            chk($sformatf("v%0d fwd_A", i), 32'(fwd_a), 32'(vecs[i].e_fa));
            chk($sformatf("v%0d fwd_B", i), 32'(fwd_b), 32'(vecs[i].e_fb));
            if (vecs[i].e_fa) chk($sformatf("v%0d fwd_A_data", i), fwd_a_data, vecs[i].e_data);
            if (vecs[i].e_fb) chk($sformatf("v%0d fwd_B_data", i), fwd_b_data, vecs[i].e_data);
            chk($sformatf("v%0d pending", i), pending, vecs[i].e_pend);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            $display("vec %0d: load=%0b sel=%0d data=%h pend=%h busy=%0b", i, load_gpr, load_sel, load_data, pending, busy);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while a FIFO entry, a pending bit and a write are all live.
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1;   alu_rd = 5'd2;  alu_data = 32'h22;
        lsu_valid = 1'b1;   lsu_rd = 5'd3;  lsu_data = 32'h33;
        sel_a = 5'd5;       sel_b = '0;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        n_vec++;
        chk("midop pre load_gpr", 32'(load_gpr), 32'd1);
        chk("midop pre pending", pending, 32'h20);
        chk("midop pre hazard_A", 32'(haz_a), 32'd1);
        chk("midop pre busy", 32'(busy), 32'd1);
        $display("vec midop-pre: load=%0b pend=%h busy=%0b", load_gpr, pending, busy);
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("midop rst load_gpr", 32'(load_gpr), 32'd0);
        chk("midop rst sel", 32'(load_sel), 32'd0);
        chk("midop rst data", load_data, 32'd0);
        chk("midop rst pending", pending, 32'd0);
        chk("midop rst hazard_A", 32'(haz_a), 32'd0);
        chk("midop rst busy", 32'(busy), 32'd0);
        chk("midop rst lsu_ready", 32'(lsu_ready), 32'd1);
        $display("vec midop-reset: load=%0b pend=%h busy=%0b", load_gpr, pending, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        n_vec++;
        chk("midop post load_gpr", 32'(load_gpr), 32'd0);
        chk("midop post busy", 32'(busy), 32'd0);
        $display("vec midop-post: load=%0b busy=%0b", load_gpr, busy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
